// File: rtl/pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// pb_debounce_multi : per-channel sync, debounce, edge, long-press and repeat
// Revision 1.0
// ============================================================================
module pb_debounce_multi #(
   parameter int CH         = 4,
   parameter int STABLE_CNT = 4,
   parameter int HOLD_CNT   = 16,
   parameter int REPEAT_CNT = 8,
   parameter int ACTIVE_LOW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic [CH-1:0] pb_in,
   output logic [CH-1:0] pb_level,
   output logic [CH-1:0] pb_press,
   output logic [CH-1:0] pb_release,
   output logic [CH-1:0] pb_hold,
   output logic [CH-1:0] pb_repeat
);

   localparam int c_STAB_W = $clog2(STABLE_CNT + 1);
   localparam int c_HOLD_W = $clog2(HOLD_CNT + 1);
   localparam int c_REP_W  = (REPEAT_CNT > 0) ? $clog2(REPEAT_CNT + 1) : 1;

   localparam logic                c_POL       = (ACTIVE_LOW != 0);
   localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(STABLE_CNT - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(HOLD_CNT);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CNT - 1);
   localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic                r_sync1, r_sync2, r_level;
      logic [c_STAB_W-1:0] r_stab;
      logic [c_HOLD_W-1:0] r_hold_cnt;
      logic [c_REP_W-1:0]  r_rep_cnt;
      logic                r_press, r_release, r_hold, r_repeat;

      logic                w_raw, w_level_nxt, w_rep_pulse;
      logic [c_STAB_W-1:0] w_stab_nxt;
      logic [c_HOLD_W-1:0] w_hold_nxt;
      logic [c_REP_W-1:0]  w_rep_nxt;

      assign w_raw = r_sync2 ^ c_POL;

      always_comb begin
         w_level_nxt = r_level;
         w_stab_nxt  = r_stab;
         w_hold_nxt  = r_hold_cnt;
         w_rep_nxt   = r_rep_cnt;
         w_rep_pulse = 1'b0;

         if (tick) begin
            if (w_raw == r_level) begin
               w_stab_nxt = '0;
            end else if (r_stab == c_STAB_LAST) begin
               w_level_nxt = w_raw;
               w_stab_nxt  = '0;
            end else begin
               w_stab_nxt = r_stab + c_STAB_W'(1);
            end
         end

         // A release decided on this tick overrides any hold/repeat firing.
         if (!w_level_nxt) begin
            w_hold_nxt = '0;
            w_rep_nxt  = '0;
         end else if (tick && r_level) begin
            if (r_hold_cnt != c_HOLD_MAX) begin
               w_hold_nxt  = r_hold_cnt + c_HOLD_W'(1);
               w_rep_pulse = (r_hold_cnt == c_HOLD_LAST);
            end else if (REPEAT_CNT > 0) begin
               if (r_rep_cnt == c_REP_LAST) begin
                  w_rep_nxt   = '0;
                  w_rep_pulse = 1'b1;
               end else begin
                  w_rep_nxt = r_rep_cnt + c_REP_W'(1);
               end
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync1    <= c_POL;
            r_sync2    <= c_POL;
            r_level    <= 1'b0;
            r_stab     <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
            r_repeat   <= 1'b0;
         end else begin
            r_sync1    <= pb_in[i];
            r_sync2    <= r_sync1;
            r_level    <= w_level_nxt;
            r_stab     <= w_stab_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_press    <= w_level_nxt & ~r_level;
            r_release  <= ~w_level_nxt & r_level;
            r_hold     <= (w_hold_nxt == c_HOLD_MAX);
            r_repeat   <= w_rep_pulse;
         end
      end

      assign pb_level[i]   = r_level;
      assign pb_press[i]   = r_press;
      assign pb_release[i] = r_release;
      assign pb_hold[i]    = r_hold;
      assign pb_repeat[i]  = r_repeat;
   end

endmodule
`default_nettype wire

// File: tb/tb_pb_debounce_multi.sv
`default_nettype none
// Self-checking bench for pb_debounce_multi: vector table plus directed
// sequences for slow tick, no-repeat build, async reset and staggered channels.
module tb_pb_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b1;
   logic [3:0] pb_in = 4'hF;
   logic [3:0] pb_level, pb_press, pb_release, pb_hold, pb_repeat;

   logic       tick_nr = 1'b1;
   logic [0:0] pb_nr = 1'b1;
   logic [0:0] nr_level, nr_press, nr_release, nr_hold, nr_repeat;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pb_debounce_multi dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .pb_in(pb_in),
      .pb_level(pb_level), .pb_press(pb_press), .pb_release(pb_release),
      .pb_hold(pb_hold), .pb_repeat(pb_repeat)
   );

   pb_debounce_multi #(.CH(1), .REPEAT_CNT(0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .tick(tick_nr), .pb_in(pb_nr),
      .pb_level(nr_level), .pb_press(nr_press), .pb_release(nr_release),
      .pb_hold(nr_hold), .pb_repeat(nr_repeat)
   );

   typedef struct {
      logic [3:0] pb;
      logic       tk;
      logic [3:0] lvl, prs, rel, hld, rpt;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(logic [3:0] pb, logic tk, logic [3:0] lvl,
                               logic [3:0] prs, logic [3:0] rel,
                               logic [3:0] hld, logic [3:0] rpt);
      vec_t v;
      v.pb = pb; v.tk = tk; v.lvl = lvl; v.prs = prs;
      v.rel = rel; v.hld = hld; v.rpt = rpt;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pb_in = 4'hF;
      pb_nr = 1'b1;
      tick  = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_all(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                            input logic [3:0] rel, input logic [3:0] hld, input logic [3:0] rpt);
      check({name, "_level"},   pb_level,   lvl);
      check({name, "_press"},   pb_press,   prs);
      check({name, "_release"}, pb_release, rel);
      check({name, "_hold"},    pb_hold,    hld);
      check({name, "_repeat"},  pb_repeat,  rpt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int rep_seen;
      int e_on, e_off;
      logic [3:0] lvl, prs, rel, hld, rpt;

      // Reset state
      do_reset();
      check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      check("reset_nr_level", nr_level, 1'b0);

      // Vector table: single press/release on ch0, then bounce on ch1
      for (int k = 1; k <= 2; k++)  add(4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 1; k <= 10; k++)
         add(4'hE, 1'b1, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 1; k <= 8; k++)
         add(4'hF, 1'b1, (k < 6) ? 4'h1 : 4'h0, 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);
      for (int j = 0; j < 20; j++)
         add(((j % 4) == 3) ? 4'hF : 4'hD, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 1; k <= 10; k++)
         add(4'hD, 1'b1, (k >= 6) ? 4'h2 : 4'h0, (k == 6) ? 4'h2 : 4'h0, 4'h0, 4'h0, 4'h0);

      foreach (vecs[i]) begin
         pb_in = vecs[i].pb;
         tick  = vecs[i].tk;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs,
                   vecs[i].rel, vecs[i].hld, vecs[i].rpt);
      end

      // Slow tick: one sample every 4 clocks, ch2 held 60 samples
      do_reset();
      tick  = 1'b0;
      pb_in = 4'hB;
      repeat (3) step();
      for (int s = 1; s <= 60; s++) begin
         tick = 1'b1;
         step();
         check($sformatf("slow_level_s%0d", s), pb_level, (s >= 4) ? 4'h4 : 4'h0);
         check($sformatf("slow_press_s%0d", s), pb_press, (s == 4) ? 4'h4 : 4'h0);
         check($sformatf("slow_hold_s%0d", s), pb_hold, (s >= 20) ? 4'h4 : 4'h0);
         check($sformatf("slow_repeat_s%0d", s), pb_repeat,
               (s >= 20 && ((s - 20) % 8) == 0) ? 4'h4 : 4'h0);
         tick = 1'b0;
         step();
         check($sformatf("slow_pulse_off_s%0d", s), {pb_press, pb_repeat}, 8'h00);
         step();
         step();
      end
      pb_in = 4'hF;
      repeat (3) step();
      for (int s = 1; s <= 4; s++) begin
         tick = 1'b1;
         step();
         check($sformatf("slow_rel_level_s%0d", s), pb_level, (s < 4) ? 4'h4 : 4'h0);
         check($sformatf("slow_rel_hold_s%0d", s), pb_hold, (s < 4) ? 4'h4 : 4'h0);
         check($sformatf("slow_rel_release_s%0d", s), pb_release, (s == 4) ? 4'h4 : 4'h0);
         check($sformatf("slow_rel_repeat_s%0d", s), pb_repeat, 4'h0);
         tick = 1'b0;
         step();
         step();
         step();
      end
      tick = 1'b1;

      // REPEAT_CNT = 0 build: single repeat at hold entry, hold falls with release
      do_reset();
      pb_nr = 1'b0;
      rep_seen = 0;
      for (int e = 1; e <= 46; e++) begin
         step();
         if (nr_repeat[0]) rep_seen++;
         if (e == 6)  check("nr_press", nr_press, 1'b1);
         if (e == 21) check("nr_hold_before", nr_hold, 1'b0);
         if (e == 22) check("nr_hold_entry", {nr_hold, nr_repeat}, 2'b11);
      end
      check("nr_repeat_count", rep_seen, 1);
      pb_nr = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (nr_repeat[0]) rep_seen++;
         if (e == 5) check("nr_pre_release", {nr_level, nr_hold, nr_release}, 3'b110);
         if (e == 6) check("nr_release", {nr_level, nr_hold, nr_release}, 3'b001);
      end
      check("nr_repeat_after_release", rep_seen, 1);

      // Async reset while ch3 held past hold entry
      do_reset();
      pb_in = 4'h7;
      repeat (22) step();
      check("rst_pre_hold", pb_hold, 4'h8);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst_async", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      step();
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         check($sformatf("rst_repress_press_e%0d", e), pb_press, (e == 6) ? 4'h8 : 4'h0);
         check($sformatf("rst_repress_level_e%0d", e), pb_level, (e == 6) ? 4'h8 : 4'h0);
      end

      // Staggered presses/releases on all channels against a closed-form model
      do_reset();
      for (int c = 0; c <= 60; c++) begin
         for (int k = 0; k < 4; k++)
            pb_in[k] = !((c >= 3 * k) && (c < 30 + 5 * k));
         step();
         lvl = 4'h0; prs = 4'h0; rel = 4'h0; hld = 4'h0; rpt = 4'h0;
         for (int k = 0; k < 4; k++) begin
            e_on  = 3 * k + 6;
            e_off = 36 + 5 * k;
            lvl[k] = (c + 1 >= e_on) && (c + 1 < e_off);
            prs[k] = (c + 1 == e_on);
            rel[k] = (c + 1 == e_off);
            hld[k] = (c + 1 >= e_on + 16) && (c + 1 < e_off);
            rpt[k] = hld[k] && (((c + 1 - (e_on + 16)) % 8) == 0);
         end
         check_all($sformatf("stag_e%0d", c + 1), lvl, prs, rel, hld, rpt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
